// File: rtl/counter_rev_slice.sv
// Cascadable up/down counter slice: sync load, carry/borrow chain, sticky wrap flag.
// One-cycle load and step latency; Rc is combinational from CI, S and cnt.
module counter_rev_slice #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S,
  input  logic             CE,
  input  logic             CI,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc,
  output logic             OV
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic             term;
  logic             step;

  // Terminal value follows S immediately, so a direction change re-arms Rc at once.
  always_comb begin
    term = S ? (&cnt_q) : ~(|cnt_q);
    Rc   = CI & term;
    step = CE & CI;
  end

  always_comb begin
    cnt_d = cnt_q;
    ov_d  = ov_q;
    if (LD) begin
      cnt_d = D;
      ov_d  = 1'b0;
    end else if (step) begin
      cnt_d = S ? (cnt_q + ONE) : (cnt_q - ONE);
      if (Rc) begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
    end
  end

  assign cnt = cnt_q;
  assign OV  = ov_q;

endmodule

// File: tb/tb_counter_rev_slice.sv
// Two cascaded slices; directed vectors push expectations, a negedge monitor checks them.
module tb_counter_rev_slice;

  logic        clk = 1'b0;
  logic        rst_n, s, ce, ci, ld;
  logic [15:0] d_lo, d_hi;
  logic [15:0] cnt_lo, cnt_hi;
  logic        rc_lo, rc_hi, ov_lo, ov_hi;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [15:0] cnt;
    logic        ov;
    logic        rc;
    bit          chk_hi;
    logic [15:0] hcnt;
    logic        hov;
    logic        hrc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  counter_rev_slice #(.WIDTH(16)) u_lo (
    .clk(clk), .rst_n(rst_n), .S(s), .CE(ce), .CI(ci), .LD(ld), .D(d_lo),
    .cnt(cnt_lo), .Rc(rc_lo), .OV(ov_lo)
  );

  counter_rev_slice #(.WIDTH(16)) u_hi (
    .clk(clk), .rst_n(rst_n), .S(s), .CE(ce), .CI(rc_lo), .LD(ld), .D(d_hi),
    .cnt(cnt_hi), .Rc(rc_hi), .OV(ov_hi)
  );

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h want %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are stable between negedge and the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "cnt", cnt_lo, e.cnt);
        chk(e.name, "ov", {15'd0, ov_lo}, {15'd0, e.ov});
        chk(e.name, "rc", {15'd0, rc_lo}, {15'd0, e.rc});
        if (e.chk_hi) begin
          chk(e.name, "hi_cnt", cnt_hi, e.hcnt);
          chk(e.name, "hi_ov", {15'd0, ov_hi}, {15'd0, e.hov});
          chk(e.name, "hi_rc", {15'd0, rc_hi}, {15'd0, e.hrc});
        end
      end
    end
  end

  task automatic cyc(input string nm, input logic rn, input logic l, input logic c_e,
                     input logic c_i, input logic dir, input logic [15:0] dl, input logic [15:0] dh,
                     input logic [15:0] e_cnt, input logic e_ov, input logic e_rc,
                     input bit h, input logic [15:0] e_hcnt, input logic e_hov, input logic e_hrc);
    exp_t e;
    rst_n = rn; ld = l; ce = c_e; ci = c_i; s = dir; d_lo = dl; d_hi = dh;
    @(posedge clk);
    #1;
    e.name = nm; e.cnt = e_cnt; e.ov = e_ov; e.rc = e_rc;
    e.chk_hi = h; e.hcnt = e_hcnt; e.hov = e_hov; e.hrc = e_hrc;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ld = 1'b0; ce = 1'b1; ci = 1'b1; s = 1'b1; d_lo = '0; d_hi = '0;
    #1;
    //        name         rn ld ce ci s  d_lo     d_hi     cnt      ov rc  hi hcnt     hov hrc
    cyc("reset0",     0, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
    cyc("reset1",     0, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("hold",     1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 16'h0000, 0, 1);

    cyc("up_load",    1, 1, 1, 1, 1, 16'hFFFE, 16'h0000, 16'hFFFE, 0, 0, 0, 16'h0000, 0, 0);
    cyc("up_term",    1, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0, 16'h0000, 0, 0);
    cyc("up_wrap",    1, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 0);
    cyc("up_sticky",  1, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0001, 1, 0, 0, 16'h0000, 0, 0);

    cyc("dn_load",    1, 1, 1, 1, 0, 16'h0001, 16'h0000, 16'h0001, 0, 0, 0, 16'h0000, 0, 0);
    cyc("dn_term",    1, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 0, 0);
    cyc("dn_wrap",    1, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 0, 16'h0000, 0, 0);
    cyc("dir_rc",     1, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'hFFFF, 1, 1, 0, 16'h0000, 0, 0);
    cyc("dir_step",   1, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 0);

    cyc("ld_prio",    1, 1, 1, 1, 1, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 16'h0000, 0, 0);
    cyc("ld_next",    1, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h1235, 0, 0, 0, 16'h0000, 0, 0);
    cyc("ci_low",     1, 0, 1, 0, 1, 16'h0000, 16'h0000, 16'h1235, 0, 0, 0, 16'h0000, 0, 0);

    cyc("cas_ld_up",  1, 1, 1, 1, 1, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 1, 1, 16'h0000, 0, 0);
    cyc("cas_up",     1, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 16'h0001, 0, 0);
    cyc("cas_ld_dn",  1, 1, 1, 1, 0, 16'h0000, 16'h0001, 16'h0000, 0, 1, 1, 16'h0001, 0, 0);
    cyc("cas_dn",     1, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 1, 16'h0000, 0, 0);
    cyc("cas_hold",   1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 1, 16'h0000, 0, 0);

    cyc("mid_load",   1, 1, 1, 1, 1, 16'h00FF, 16'h0000, 16'h00FF, 0, 0, 0, 16'h0000, 0, 0);
    cyc("mid_step",   1, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0100, 0, 0, 0, 16'h0000, 0, 0);
    cyc("mid_reset",  0, 1, 1, 1, 1, 16'hABCD, 16'h5555, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_rev_slice.md
# counter_rev_slice

Cascadable reversible (up/down) counter slice with synchronous parallel load, a carry/borrow input, and a sticky wrap flag. It consumes the ripple-carry output `Rc` of an identical lower-order slice on its `CI` input and produces its own `Rc` for the next slice. Two or more slices therefore form wide up/down counters, for example 32-bit from two slices. It sits on the counting datapath next to the existing 16-bit reversible counters and reuses their `S` direction convention.

## Interface
- `WIDTH`, default 16: counter width in bits, minimum 2.
- `clk`, input, 1: clock; all state changes on rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `S`, input, 1: direction; 1 counts up, 0 counts down.
- `CE`, input, 1: count enable, global for the whole chain.
- `CI`, input, 1: carry/borrow in. Tie to 1 on the least-significant slice; otherwise connect to the lower slice's `Rc`.
- `LD`, input, 1: synchronous parallel load.
- `D`, input, WIDTH: load value.
- `cnt`, output, WIDTH: current count, registered.
- `Rc`, output, 1: ripple carry/borrow out, combinational.
- `OV`, output, 1: sticky wrap flag, registered.

## Operation
- Terminal condition: `term = S ? (cnt == all-ones) : (cnt == 0)`.
- `Rc = CI & term`. `Rc` is purely combinational from `CI`, `S` and `cnt`, and does not depend on `CE` or `LD`. This keeps a chain settled within one cycle.
- Step condition: `step = CE & CI`.
- Per-edge priority, highest first:
  - `rst_n == 0`: `cnt <= 0`, `OV <= 0`.
  - `LD == 1`: `cnt <= D`, `OV <= 0`. `CE`, `CI` and `S` are ignored.
  - `step == 1` and `S == 1`: `cnt <= cnt + 1`, modulo 2^WIDTH.
  - `step == 1` and `S == 0`: `cnt <= cnt - 1`, modulo 2^WIDTH.
  - Otherwise: `cnt` holds.
- Wrap behaviour:
  - all-ones to 0 when counting up; 0 to all-ones when counting down.
  - `OV <= 1` on any step taken while `Rc == 1`, i.e. on a wrap.
  - `OV` stays set until the next reset or load.
- Direction change: `S` may change on any cycle. The next step uses the new `S` with no dead cycle. `Rc` re-evaluates immediately against the new terminal value.
- Cascading:
  - Every slice sees the same `clk`, `S`, `CE` and `LD`.
  - A higher slice steps only on the edge where every lower slice is at its terminal value. This gives correct multi-word increment and decrement.
  - Per-slice `D` provides wide load.
- Arithmetic is unsigned modulo 2^WIDTH. No saturation.

## Timing
- Reset values after an edge with `rst_n == 0`: `cnt = 0`, `OV = 0`. `Rc` then equals `CI & ~S` (the count is 0, so the down terminal condition is met).
- Reset mid-count overrides `LD` and `step` on the same edge. No partial update.
- Load latency: 1 cycle. `D` is visible on `cnt` after the edge where `LD == 1`.
- Count latency: 1 cycle per step.
- `Rc` reflects the current `cnt` and `CI` with zero cycle latency. Chain settle time is N × (compare + AND) within the clock period. The critical path is the full chain.
- `OV` updates on the same edge as the wrapping step.

## Test plan
- Reset and hold: drive `rst_n = 0` for 2 cycles with `CE = 1`, `S = 1`. Then `cnt = 0x0000` and `OV = 0`. Release reset and set `CE = 0` for 3 cycles: `cnt` stays at `0x0000`. With `S = 0`, `Rc = 1`.
- Up wrap: load `0xFFFE`, then `S = 1`, `CE = 1`, `CI = 1`.
  - `cnt` goes `0xFFFE` → `0xFFFF` (with `Rc = 1`) → `0x0000`.
  - `OV` becomes 1 on the wrap edge and stays 1 for later counting.
- Down wrap and direction change: load `0x0001`, `S = 0`.
  - `cnt` goes `0x0001` → `0x0000` (`Rc = 1`) → `0xFFFF`, `OV = 1`.
  - Then set `S = 1`: `cnt` goes `0xFFFF` (`Rc = 1`) → `0x0000`.
- Load priority: with `CE = 1`, `CI = 1`, assert `LD = 1`, `D = 0x1234`. Then `cnt = 0x1234`, with no increment on that edge, and `OV` is cleared. The following step gives `0x1235`.
- Cascade of two slices, with the low slice's `Rc` driving the high slice's `CI`:
  - Load `{0x0000, 0xFFFF}` and count up once: result `{0x0001, 0x0000}`.
  - Load `{0x0001, 0x0000}` and count down once: result `{0x0000, 0xFFFF}`.
  - The high slice's `OV` stays 0 throughout.
- Reset mid-count: while counting up from `0x00FF` with `LD = 1` asserted on the same edge, assert `rst_n = 0`. Then `cnt = 0x0000` and `OV = 0`.
